// File: rtl/uart_alu_ctrl_pkg.sv
// Shared state encodings, default frame header and ALU opcode values for the
// UART/ALU frame sequencer, its ALU and its benches.
package uart_alu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_OP   = 3'd3,
        S_EXEC = 3'd4,
        S_SEND = 3'd5,
        S_WAIT = 3'd6
    } state_t;

    localparam logic [7:0] HEADER_DEF = 8'hFF;

    typedef enum logic [5:0] {
        OP_SRL = 6'h02,
        OP_SRA = 6'h03,
        OP_ADD = 6'h20,
        OP_SUB = 6'h22,
        OP_AND = 6'h24,
        OP_OR  = 6'h25,
        OP_XOR = 6'h26,
        OP_NOR = 6'h27
    } alu_op_e;

endpackage

// File: rtl/frame_timer.sv
// Inter-byte watchdog: counts while enabled, pulses expire at TIMEOUT_CYC-1 and
// saturates there so it can never wrap back to zero.
module frame_timer #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYC);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                   cnt <= '0;
        else if (clr)                 cnt <= '0;
        else if (en && cnt != LIMIT)  cnt <= cnt + 1'b1;
    end

    assign expire = en && (cnt == LIMIT);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between uart_rx/uart_tx and the ALU: [HEADER] A, B, OP in,
// one result byte out. Build option HEADER_CHECK_EN adds the header byte.
module uart_alu_ctrl
    import uart_alu_ctrl_pkg::*;
#(
    parameter int              DBIT        = 8,
    parameter int              OP_W        = 6,
    parameter logic [DBIT-1:0] HEADER      = DBIT'(HEADER_DEF),
    parameter int              TIMEOUT_CYC = 1_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DBIT-1:0] rx_data,
    input  logic            rx_done,
    input  logic            tx_done,
    input  logic [DBIT-1:0] alu_result,
    output logic [DBIT-1:0] alu_a,
    output logic [DBIT-1:0] alu_b,
    output logic [OP_W-1:0] alu_op,
    output logic [DBIT-1:0] tx_data,
    output logic            tx_start,
    output logic            busy,
    output logic            frame_err
);

`ifdef HEADER_CHECK_EN
    localparam state_t IDLE_ST = S_HDR;
`else
    localparam state_t IDLE_ST = S_A;
`endif

    state_t state, next;
    logic   tmr_clr, tmr_en, expire;
    logic   err_set, ld_a, ld_b, ld_op;

    frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE_ST;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            tx_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= next;
            frame_err <= err_set;
            if (ld_a)  alu_a  <= rx_data;
            if (ld_b)  alu_b  <= rx_data;
            if (ld_op) alu_op <= rx_data[OP_W-1:0];
            if (state == S_EXEC) tx_data <= alu_result;
        end
    end

    // A received byte always takes priority over a simultaneous timeout.
    always_comb begin
        next    = state;
        tmr_en  = 1'b0;
        err_set = 1'b0;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_op   = 1'b0;
        case (state)
            S_HDR: begin
                if (rx_done) begin
                    if (rx_data == HEADER) next = S_A;
                    else                   err_set = 1'b1;
                end
            end
            S_A: begin
`ifdef HEADER_CHECK_EN
                tmr_en = 1'b1;
`endif
                if (rx_done) begin
                    ld_a = 1'b1;
                    next = S_B;
                end else if (expire) begin
                    next    = IDLE_ST;
                    err_set = 1'b1;
                end
            end
            S_B: begin
                tmr_en = 1'b1;
                if (rx_done) begin
                    ld_b = 1'b1;
                    next = S_OP;
                end else if (expire) begin
                    next    = IDLE_ST;
                    err_set = 1'b1;
                end
            end
            S_OP: begin
                tmr_en = 1'b1;
                if (rx_done) begin
                    ld_op = 1'b1;
                    next  = S_EXEC;
                end else if (expire) begin
                    next    = IDLE_ST;
                    err_set = 1'b1;
                end
            end
            S_EXEC:  next = S_SEND;
            S_SEND:  next = S_WAIT;
            S_WAIT:  if (tx_done) next = IDLE_ST;
            default: next = IDLE_ST;
        endcase
        // Every accepted byte moves the state, so a state change covers both clear causes.
        tmr_clr = (next != state);
    end

    assign tx_start = (state == S_SEND);
    assign busy     = (state != S_HDR) && (state != S_A);

endmodule
